// File: rtl/multicycle_control_unit.sv
// Moore sequencing controller for the multi-cycle RISC-V datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       branch_o,
    output logic       adr_src_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd13;

    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_JAL  = 7'h6F;

    logic [3:0] state_q, state_d;
    logic       pc_wr, ir_wr, retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_wr        = 1'b0;
        ir_wr        = 1'b0;
        retire       = 1'b0;
        branch_o     = 1'b0;
        adr_src_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'd0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = 2'd0;
        result_src_o = 2'd0;
        illegal_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o   = 1'b1;
                alu_src_b_o  = 2'd2;
                result_src_o = 2'd2;
                pc_wr        = mem_ready_i;
                ir_wr        = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                state_d = (op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                adr_src_o  = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src_o = 2'd1;
                reg_write_o  = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
                retire      = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'd2;
                alu_op_o    = 2'd2;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                alu_op_o    = 2'd2;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'd2;
                alu_op_o    = 2'd1;
                branch_o    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while ALU forms oldPC+4
                pc_wr       = 1'b1;
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd2;
                state_d     = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                state_d     = S_JAL;
            end
            S_LUI: begin
                alu_src_a_o = 2'd3;
                alu_src_b_o = 2'd1;
                state_d     = S_ALU_WB;
            end
            S_TRAP: begin
                illegal_o = 1'b1;
                state_d   = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // reset is async, so the write/retire strobes are masked combinationally
    assign pc_write_o = pc_wr & reset;
    assign ir_write_o = ir_wr & reset;
    assign retire_o   = retire & reset;
    assign state_o    = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencing controller for the multi-cycle RISC-V datapath. It walks each instruction through fetch, decode, execute, memory and write-back cycles. It drives the select and enable lines for the PC, instruction register, memory, register file and ALU. The opcode it decodes is the same 7-bit field the immediate unit consumes, so the immediate is valid from DECODE onward.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_i  input  7  opcode field, instruction-register bits [6:0].
- mem_ready_i  input  1  memory completes the current read or write this cycle.
- pc_write_o  output  1  unconditional PC load enable.
- ir_write_o  output  1  instruction-register load enable.
- branch_o  output  1  datapath loads PC when `branch_o & zero`.
- adr_src_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  output  1  memory read request.
- mem_write_o  output  1  memory write request.
- reg_write_o  output  1  register-file write enable.
- alu_src_a_o  output  2  ALU operand A select: 0 = PC, 1 = oldPC, 2 = rs1, 3 = zero.
- alu_src_b_o  output  2  ALU operand B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- alu_op_o  output  2  ALU operation: 0 = add, 1 = subtract, 2 = decode from funct fields.
- result_src_o  output  2  result select: 0 = ALUOut, 1 = memory data, 2 = ALU result.
- retire_o  output  1  one-cycle pulse on the final cycle of each instruction.
- illegal_o  output  1  high while in TRAP.
- state_o  output  4  current state encoding, for debug.

## Operation
- Supported opcodes: 0x33 R, 0x13 I-ALU, 0x03 lw, 0x23 sw, 0x63 branch, 0x6F jal, 0x67 jalr, 0x37 lui.
- Any output not listed for a state is 0.
- States, encoding, outputs and next state:
  - 0 FETCH:
    - mem_read=1, a=0, b=2, alu_op=0, result_src=2.
    - pc_write=ir_write=mem_ready_i (Mealy).
    - Stays in FETCH while !mem_ready_i; goes to DECODE when mem_ready_i.
  - 1 DECODE:
    - a=1, b=1, alu_op=0, so ALUOut = oldPC + imm.
    - Next state by op_i: 0x03/0x23 → MEM_ADDR, 0x33 → EXEC_R, 0x13 → EXEC_I, 0x63 → BRANCH, 0x6F → JAL, 0x67 → JALR, 0x37 → LUI.
    - Any other opcode → TRAP.
  - 2 MEM_ADDR: a=2, b=1, alu_op=0. Next state is MEM_READ if op_i=0x03, otherwise MEM_WRITE.
  - 3 MEM_READ: mem_read=1, adr_src=1. Holds until mem_ready_i, then MEM_WB.
  - 4 MEM_WB: result_src=1, reg_write=1, retire=1. Next state FETCH.
  - 5 MEM_WRITE: mem_write=1, adr_src=1. Holds until mem_ready_i; retire=mem_ready_i; then FETCH.
  - 6 EXEC_R: a=2, b=0, alu_op=2. Next state ALU_WB.
  - 7 EXEC_I: a=2, b=1, alu_op=2. Next state ALU_WB.
  - 8 ALU_WB: result_src=0, reg_write=1, retire=1. Next state FETCH.
  - 9 BRANCH: a=2, b=0, alu_op=1, result_src=0, branch=1, retire=1. Next state FETCH.
  - 10 JAL:
    - pc_write=1, result_src=0, so PC takes the target already in ALUOut.
    - a=1, b=2, alu_op=0, so ALUOut becomes oldPC + 4.
    - Next state ALU_WB.
  - 11 JALR: a=2, b=1, alu_op=0, so ALUOut = rs1 + imm. Next state JAL.
  - 12 LUI: a=3, b=1, alu_op=0. Next state ALU_WB.
  - 13 TRAP: illegal_o=1, all enables 0. Terminal: leaves only on reset.
- Encodings 14–15 are unreachable. If entered, the next state is TRAP.
- op_i is sampled only in DECODE and MEM_ADDR. Changes in other states are ignored.

## Timing
- Reset:
  - While reset is low, the state is FETCH (asynchronous) and pc_write_o, ir_write_o, retire_o are forced to 0.
  - All other outputs take their FETCH values.
  - Deasserting reset mid-instruction restarts at FETCH with no partial write.
- Cycles per instruction with zero memory wait:
  - lw 5; sw 4; R/I/lui 4; branch 3; jal 4; jalr 5.
  - Each cycle of mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Request outputs stay stable until mem_ready_i is seen. mem_ready_i outside those three states is ignored.
- retire_o pulses exactly once per completed instruction and never in TRAP.

## Test plan
- Reset asserted mid-EXEC_R, then released → state_o=0 and mem_read_o=1 in the first cycle; no reg_write_o pulse.
- FETCH with mem_ready_i low for 3 cycles, then op 0x33 → state sequence 0,0,0,0,1,6,8,0; reg_write_o high only in state 8; retire_o count 1.
- op 0x03 with MEM_READ wait of 2 cycles → sequence 0,1,2,3,3,3,4,0; adr_src_o=1 in state 3; result_src_o=1 in state 4.
- op 0x63 → branch_o=1, alu_op_o=1 for exactly one cycle; total of 3 cycles.
- op 0x67 → sequence 0,1,11,10,8,0; pc_write_o=1 in state 10; state 8 has result_src_o=0 and reg_write_o=1.
- op 0x7F → state 13, illegal_o=1 sustained for 20 cycles with mem_ready_i toggling; no enables; exits only on reset.
